// File: rtl/wb_ram_arbiter_pkg.sv
// wb_ram_arbiter_pkg: arbiter state encodings, Wishbone B3 cycle-type codes and an
// index-width helper shared by the arbiter, its round-robin picker and benches.
package wb_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_BUSY  = 2'b01,
    ARB_DRAIN = 2'b10
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick: combinational round-robin winner search, starting one past `last`
// and wrapping; yields a one-hot grant, its index and a valid flag.
module wb_arb_rr_pick
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  localparam int LW = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [LW-1:0]          last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [LW-1:0]          gnt_idx,
  output logic                   valid
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (req[k] && (k == ((int'(last) + off) % NUM_MASTERS))) begin
          gnt     = '0;
          gnt[k]  = 1'b1;
          gnt_idx = LW'(k);
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: Wishbone B3 N:1 round-robin arbiter in front of the shared on-chip RAM.
// Define WB_ARB_TIMEOUT_EN to add the ack watchdog and the DRAIN state.
//
//   state | meaning
//   IDLE  | no owner; pick the next requester after `last`
//   BUSY  | owner's cycle passed to the slave until it drops cyc
//   DRAIN | watchdog fired; slave held idle until the owner drops cyc
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_n_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]              m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]              m_bte_i,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [NUM_MASTERS-1:0]                m_rty_o,
  output logic [ADDR_WIDTH-1:0]                 s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  output logic                                  s_we_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic [2:0]                            s_cti_o,
  output logic [1:0]                            s_bte_o,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  input  logic                                  s_rty_i,
  output logic [NUM_MASTERS-1:0]                gnt_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = idx_width(NUM_MASTERS);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit watchdog");
  end

  arb_state_t             state, state_nx;
  logic [NUM_MASTERS-1:0] gnt_q, pick_gnt;
  logic [LW-1:0]          g_idx, last_q, pick_idx;
  logic                   pick_valid;
  logic                   g_cyc, g_stb;

`ifdef WB_ARB_TIMEOUT_EN
  logic       slv_term, timeout_hit;
  logic [7:0] wd_cnt;
`endif

  wb_arb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req     (m_cyc_i),
    .last    (last_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign g_cyc   = m_cyc_i[g_idx];
  assign g_stb   = m_stb_i[g_idx];
  assign gnt_o   = gnt_q;
  assign m_dat_o = s_dat_i;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state  <= ARB_IDLE;
      gnt_q  <= '0;
      g_idx  <= '0;
      last_q <= LW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && pick_valid) begin
        gnt_q  <= pick_gnt;
        g_idx  <= pick_idx;
        last_q <= pick_idx;
      end else if (state_nx == ARB_IDLE) begin
        gnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: if (pick_valid) state_nx = ARB_BUSY;
      ARB_BUSY: begin
`ifdef WB_ARB_TIMEOUT_EN
        if (timeout_hit)  state_nx = ARB_DRAIN;
        else if (!g_cyc)  state_nx = ARB_IDLE;
`else
        if (!g_cyc)       state_nx = ARB_IDLE;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ARB_DRAIN: if (!g_cyc) state_nx = ARB_IDLE;
`endif
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state == ARB_BUSY) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (g_idx == LW'(k)) begin
          s_adr_o    = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          s_dat_o    = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
          s_sel_o    = m_sel_i[k*SW +: SW];
          s_we_o     = m_we_i[k];
          s_cti_o    = m_cti_i[k*3 +: 3];
          s_bte_o    = m_bte_i[k*2 +: 2];
          m_ack_o[k] = s_ack_i;
          m_err_o[k] = s_err_i;
          m_rty_o[k] = s_rty_i;
        end
      end
      s_cyc_o = g_cyc;
      s_stb_o = g_stb;
`ifdef WB_ARB_TIMEOUT_EN
      // The slave is silent by definition here, so only the synthetic err reaches the owner.
      if (timeout_hit) begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_rty_o = '0;
        m_err_o = gnt_q;
      end
`endif
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign slv_term    = s_ack_i | s_err_i | s_rty_i;
  assign timeout_hit = (state == ARB_BUSY) && g_stb && !slv_term && (wd_cnt == 8'd0);

  // Down-counter reloaded whenever the owner is not stalled on an unanswered strobe.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wd_cnt <= 8'(TIMEOUT_CYCLES);
    end else if ((state == ARB_BUSY) && g_stb && !slv_term && !timeout_hit) begin
      wd_cnt <= wd_cnt - 8'd1;
    end else begin
      wd_cnt <= 8'(TIMEOUT_CYCLES);
    end
  end
`endif

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter: random multi-master traffic against a transaction-level ownership
// model and a small RAM model; build with WB_ARB_TIMEOUT_EN to exercise the watchdog.
`timescale 1ns/1ps
module tb_wb_ram_arbiter;
  import wb_ram_arbiter_pkg::*;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_n_i = 1'b0;
  logic [NM*AW-1:0]  m_adr_i = '0;
  logic [NM*DW-1:0]  m_dat_i = '0;
  logic [NM*SW-1:0]  m_sel_i = '0;
  logic [NM-1:0]     m_we_i = '0, m_cyc_i = '0, m_stb_i = '0;
  logic [NM*3-1:0]   m_cti_i = '0;
  logic [NM*2-1:0]   m_bte_i = '0;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, gnt_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i = '0;
  logic              s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;

  wb_ram_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Master-side transaction state.
  int            beats [NM];
  int            gap   [NM];
  logic [AW-1:0] addr  [NM];
  logic [DW-1:0] wdat  [NM];
  logic [SW-1:0] sel   [NM];
  logic          we    [NM];
  logic          stb   [NM];
  logic          burst [NM];
  logic [1:0]    bte   [NM];
  logic [2:0]    cti   [NM];

  // Reference model: who owns the RAM, who was served last, watchdog stall length.
  logic [DW-1:0] mem [16];
  int            owner = -1;
  int            last  = NM - 1;
  int            stall = 0;
  bit            drain = 1'b0;
  bit            hang  = 1'b0;
  logic [NM-1:0] prev_gnt = '0;
  logic [NM-1:0] gnt_log [$];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NM-1:0] onehot(input int i);
    logic [NM-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Rotation: the requester with the smallest circular distance after `lst` wins.
  function automatic int rr_pick(input logic [NM-1:0] req, input int lst);
    int best, bd, d;
    best = -1;
    bd   = NM + 1;
    for (int k = 0; k < NM; k++) begin
      d = (k - lst - 1 + 2 * NM) % NM;
      if (req[k] && d < bd) begin
        bd   = d;
        best = k;
      end
    end
    return best;
  endfunction

  // mode 0: random traffic, 1: every idle master starts now, 2: no new starts.
  task automatic step(input int mode, input bit do_rst);
    bit            busy, tmo, e_cyc, e_stb, ack, err, rty;
    logic [NM-1:0] e_gnt, e_ack, e_err, e_rty;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [9:0]    e_ctl;
    int            r;

    wb_rst_n_i = !do_rst;
    for (int k = 0; k < NM; k++) begin
      if (beats[k] == 0) begin
        if (gap[k] > 0) gap[k]--;
        else if (mode == 1 || (mode == 0 && $urandom_range(0, 5) == 0)) begin
          beats[k] = (mode == 1) ? 1 : int'($urandom_range(1, 4));
          burst[k] = beats[k] > 1;
          addr[k]  = 32'h100 | (32'($urandom_range(0, 15)) << 2);
          we[k]    = 1'($urandom_range(0, 1));
          wdat[k]  = $urandom;
          sel[k]   = 4'($urandom_range(0, 15));
          bte[k]   = 2'($urandom_range(0, 3));
        end
      end
      stb[k] = (beats[k] > 0) && (mode != 0 || $urandom_range(0, 3) != 0);
      cti[k] = (beats[k] > 1) ? CTI_INCR : (burst[k] ? CTI_EOB : CTI_CLASSIC);
      m_adr_i[k*AW +: AW] = addr[k];
      m_dat_i[k*DW +: DW] = wdat[k];
      m_sel_i[k*SW +: SW] = sel[k];
      m_we_i[k]           = we[k];
      m_cyc_i[k]          = beats[k] > 0;
      m_stb_i[k]          = stb[k];
      m_cti_i[k*3 +: 3]   = cti[k];
      m_bte_i[k*2 +: 2]   = bte[k];
    end

    busy  = (owner >= 0) && !drain;
    tmo   = 1'b0;
    e_cyc = 1'b0;
    e_stb = 1'b0;
    e_adr = '0;
    e_dat = '0;
    e_ctl = '0;
    e_gnt = (owner >= 0) ? onehot(owner) : '0;
    if (busy) begin
`ifdef WB_ARB_TIMEOUT_EN
      tmo = stb[owner] && (stall == TO);
`endif
      e_cyc = (beats[owner] > 0) && !tmo;
      e_stb = stb[owner] && !tmo;
      e_adr = addr[owner];
      e_dat = wdat[owner];
      e_ctl = {we[owner], sel[owner], cti[owner], bte[owner]};
    end

    #1;
    if (mode != 0) hang = 1'b0;
    else if ($urandom_range(0, 63) == 0) hang = !hang;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
    s_dat_i = $urandom;
    if (e_stb && !hang) begin
      r       = int'($urandom_range(0, 11));
      s_ack_i = r < 7;
      s_err_i = r == 7;
      s_rty_i = r == 8;
      s_dat_i = mem[s_adr_o[5:2]];
    end
    ack = s_ack_i;
    err = s_err_i;
    rty = s_rty_i;
    e_ack = (busy && ack) ? onehot(owner) : '0;
    e_err = (busy && (err || tmo)) ? onehot(owner) : '0;
    e_rty = (busy && rty) ? onehot(owner) : '0;
    #1;

    chk_eq("gnt", 64'(gnt_o), 64'(e_gnt));
    chk_eq("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
    chk_eq("s_stb", 64'(s_stb_o), 64'(e_stb));
    chk_eq("s_adr", 64'(s_adr_o), 64'(e_adr));
    chk_eq("s_dat", 64'(s_dat_o), 64'(e_dat));
    chk_eq("s_ctl", 64'({s_we_o, s_sel_o, s_cti_o, s_bte_o}), 64'(e_ctl));
    chk_eq("m_ack", 64'(m_ack_o), 64'(e_ack));
    chk_eq("m_err", 64'(m_err_o), 64'(e_err));
    chk_eq("m_rty", 64'(m_rty_o), 64'(e_rty));
    if (busy && ack && !we[owner]) chk_eq("m_dat", 64'(m_dat_o), 64'(mem[addr[owner][5:2]]));

    if (gnt_o != '0 && prev_gnt == '0) gnt_log.push_back(gnt_o);
    prev_gnt = gnt_o;

    @(posedge wb_clk_i);
    #1;
    if (do_rst) begin
      owner = -1;
      last  = NM - 1;
      drain = 1'b0;
      stall = 0;
      for (int k = 0; k < NM; k++) begin
        beats[k] = 0;
        gap[k]   = 0;
      end
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      if (e_stb && !(ack || err || rty)) stall++;
      else stall = 0;
`endif
      if (owner < 0) begin
        if (m_cyc_i != '0) begin
          owner = rr_pick(m_cyc_i, last);
          last  = owner;
        end
      end else if (tmo) begin
        drain = 1'b1;
      end else if (beats[owner] == 0) begin
        owner = -1;
        drain = 1'b0;
      end
      for (int k = 0; k < NM; k++) begin
        if (e_ack[k] || e_err[k] || e_rty[k]) begin
          if (e_ack[k]) begin
            if (we[k]) mem[addr[k][5:2]] = wdat[k];
            beats[k]--;
            addr[k] = addr[k] + 32'd4;
            wdat[k] = $urandom;
          end else begin
            beats[k] = 0;
          end
          if (beats[k] == 0) gap[k] = int'($urandom_range(0, 2));
        end
      end
    end
  endtask

  logic [NM-1:0] exp_order [3] = '{3'b001, 3'b010, 3'b100};

  initial begin
    for (int k = 0; k < NM; k++) begin
      beats[k] = 0; gap[k] = 0; addr[k] = 32'h100; wdat[k] = '0; sel[k] = '0;
      we[k] = 1'b0; stb[k] = 1'b0; burst[k] = 1'b0; bte[k] = '0; cti[k] = '0;
    end
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge wb_clk_i);
    #1;

    // Simultaneous requests straight out of reset: rotation from last=2 gives 0, 1, 2.
    step(2, 1'b1);
    gnt_log.delete();
    step(1, 1'b0);
    repeat (60) step(2, 1'b0);
    chk_eq("order_len", 64'(gnt_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < gnt_log.size()) chk_eq("order", 64'(gnt_log[i]), 64'(exp_order[i]));
    end

    for (int i = 0; i < 4000; i++) step(0, $urandom_range(0, 299) == 0);
    step(2, 1'b1);
    repeat (40) step(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
